// File: rtl/chroni_vram_pkg.sv
// Shared definitions for the chroni VRAM port: FSM state encoding, VRAM
// address geometry, legal parameter ranges and the video address mapping.
package chroni_vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 21;
    localparam int unsigned VRAM_PAGE_W = 8;
    localparam int unsigned VRAM_OFS_W  = 13;
    localparam int unsigned DATA_W      = 8;

    localparam int unsigned RD_LATENCY_MIN     = 1;
    localparam int unsigned RD_LATENCY_MAX     = 3;
    localparam int unsigned VID_STREAK_MAX_MIN = 1;
    localparam int unsigned VID_STREAK_MAX_MAX = 255;

    // Latency counter only needs to reach RD_LATENCY_MAX-1.
    localparam int unsigned LAT_W    = 2;
    localparam int unsigned STREAK_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VID_RD,
        ST_VID_ACK,
        ST_CPU_RD,
        ST_CPU_WR,
        ST_CPU_ACK
    } state_t;

    // Page and offset are concatenated without carry.
    function automatic logic [VRAM_ADDR_W-1:0] vid_vram_addr(
        input logic [VRAM_PAGE_W-1:0] page,
        input logic [VRAM_OFS_W-1:0]  ofs
    );
        return {page, ofs};
    endfunction

endpackage

// File: rtl/chroni_vram_port_if.sv
// Bus bundle of the chroni VRAM port: chroni fetch side, CPU side and VRAM
// macro side.
//   slave  : view of chroni_vram_port (consumes requests, drives acks and VRAM)
//   master : view of the surroundings (chroni, CPU decoder, VRAM model)
interface chroni_vram_port_if;
    import chroni_vram_pkg::*;

    logic [VRAM_OFS_W-1:0]  vid_addr;
    logic [VRAM_PAGE_W-1:0] vid_addr_page;
    logic                   vid_rd_req;
    logic                   vid_rd_ack;
    logic [DATA_W-1:0]      vid_data;

    logic [VRAM_ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0]      cpu_wdata;
    logic                   cpu_we;
    logic                   cpu_re;
    logic                   cpu_ack;
    logic [DATA_W-1:0]      cpu_rdata;

    logic [VRAM_ADDR_W-1:0] mem_addr;
    logic                   mem_we;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;

    modport slave (
        input  vid_addr, vid_addr_page, vid_rd_req,
        output vid_rd_ack, vid_data,
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output cpu_ack, cpu_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output vid_addr, vid_addr_page, vid_rd_req,
        input  vid_rd_ack, vid_data,
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  cpu_ack, cpu_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/chroni_vram_req_slot.sv
// Per-requester arming: a level request yields exactly one transaction until
// the line is seen low again.
//   sys_clk, reset_n : clock, async active-low reset
//   req              : level request line
//   ack              : registered acknowledge pulse for this requester
//   pending_c        : request is live and armed (combinational)
module chroni_vram_req_slot (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic req,
    input  logic ack,
    output logic pending_c
);

    logic armed;

    // A low sample re-arms even during the ack cycle, so a requester that
    // drops the line together with the ack can re-request immediately.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b1;
        end else if (!req) begin
            armed <= 1'b1;
        end else if (ack) begin
            armed <= 1'b0;
        end
    end

    assign pending_c = req & armed;

endmodule

// File: rtl/chroni_vram_port.sv
// Arbitrates chroni video byte fetches and CPU reads/writes onto one
// single-port synchronous VRAM. Video has priority; a streak limit bounds
// how many video grants may pass a waiting CPU request.
//   sys_clk, reset_n : clock, async active-low reset
//   bus (slave)      : chroni rd_req/rd_ack, CPU we/re/ack, VRAM addr/we/data
module chroni_vram_port
    import chroni_vram_pkg::*;
#(
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned VID_STREAK_MAX = 8
) (
    input logic               sys_clk,
    input logic               reset_n,
    chroni_vram_port_if.slave bus
);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_rd_latency
        $error("chroni_vram_port: RD_LATENCY out of range");
    end
    if (VID_STREAK_MAX < VID_STREAK_MAX_MIN || VID_STREAK_MAX > VID_STREAK_MAX_MAX) begin : g_bad_streak
        $error("chroni_vram_port: VID_STREAK_MAX out of range");
    end

    localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(RD_LATENCY - 1);
    localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(VID_STREAK_MAX);

    state_t                 state;
    logic [LAT_W-1:0]       lat_cnt;
    logic [STREAK_W-1:0]    streak;

    logic                   vid_rd_ack_q;
    logic [DATA_W-1:0]      vid_data_q;
    logic                   cpu_ack_q;
    logic [DATA_W-1:0]      cpu_rdata_q;
    logic [VRAM_ADDR_W-1:0] mem_addr_q;
    logic                   mem_we_q;
    logic [DATA_W-1:0]      mem_wdata_q;

    logic vid_pend_c;
    logic cpu_pend_c;
    logic streak_full_c;
    logic vid_go_c;
    logic cpu_go_c;

    chroni_vram_req_slot u_vid_slot (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .req       (bus.vid_rd_req),
        .ack       (vid_rd_ack_q),
        .pending_c (vid_pend_c)
    );

    chroni_vram_req_slot u_cpu_slot (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .req       (bus.cpu_we | bus.cpu_re),
        .ack       (cpu_ack_q),
        .pending_c (cpu_pend_c)
    );

    // IDLE arbitration: video wins unless a CPU request has waited out the streak.
    assign streak_full_c = (streak == STREAK_TOP);
    assign vid_go_c      = (state == ST_IDLE) && vid_pend_c && !(cpu_pend_c && streak_full_c);
    assign cpu_go_c      = (state == ST_IDLE) && cpu_pend_c && !vid_go_c;

    // Transaction FSM with registered outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            lat_cnt      <= '0;
            streak       <= '0;
            vid_rd_ack_q <= 1'b0;
            vid_data_q   <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            vid_rd_ack_q <= 1'b0;
            cpu_ack_q    <= 1'b0;
            mem_we_q     <= 1'b0;

            // Streak only counts video grants that overtake a waiting CPU.
            if (!cpu_pend_c || cpu_go_c) begin
                streak <= '0;
            end else if (vid_go_c && !streak_full_c) begin
                streak <= streak + STREAK_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    lat_cnt <= '0;
                    if (vid_go_c) begin
                        mem_addr_q <= vid_vram_addr(bus.vid_addr_page, bus.vid_addr);
                        state      <= ST_VID_RD;
                    end else if (cpu_go_c) begin
                        mem_addr_q <= bus.cpu_addr;
                        if (bus.cpu_we) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= bus.cpu_wdata;
                            state       <= ST_CPU_WR;
                        end else begin
                            state <= ST_CPU_RD;
                        end
                    end
                end
                ST_VID_RD: begin
                    if (lat_cnt == LAT_LAST) begin
                        vid_data_q   <= bus.mem_rdata;
                        vid_rd_ack_q <= 1'b1;
                        state        <= ST_VID_ACK;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                ST_CPU_RD: begin
                    if (lat_cnt == LAT_LAST) begin
                        cpu_rdata_q <= bus.mem_rdata;
                        cpu_ack_q   <= 1'b1;
                        state       <= ST_CPU_ACK;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                ST_CPU_WR: begin
                    cpu_ack_q <= 1'b1;
                    state     <= ST_CPU_ACK;
                end
                ST_VID_ACK, ST_CPU_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.vid_rd_ack = vid_rd_ack_q;
    assign bus.vid_data   = vid_data_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_chroni_vram_port.sv
// Directed bench for chroni_vram_port with a behavioural VRAM (latency 1:
// data follows the registered mem_addr within the same cycle).
module tb_chroni_vram_port;
    import chroni_vram_pkg::*;

    logic sys_clk = 1'b0;
    logic reset_n;

    always #5 sys_clk = ~sys_clk;

    chroni_vram_port_if bus();

    chroni_vram_port #(
        .RD_LATENCY     (1),
        .VID_STREAK_MAX (8)
    ) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // VRAM model: preload once on the first edge, then honour mem_we.
    logic [7:0] vram [0:(1<<21)-1];
    bit         preloaded = 1'b0;

    always @(posedge sys_clk) begin
        if (!preloaded) begin
            for (int a = 1025; a <= 1092; a++) begin
                vram[a] <= 8'(a) + 8'h40;
            end
            preloaded <= 1'b1;
        end else if (bus.mem_we) begin
            vram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = vram[bus.mem_addr];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int vid_acks     = 0;
    int cpu_acks     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and tally acks visible in that cycle.
    task automatic tick();
        @(negedge sys_clk);
        cyc++;
        if (bus.vid_rd_ack === 1'b1) vid_acks++;
        if (bus.cpu_ack === 1'b1)    cpu_acks++;
    endtask

    // Chroni-style read: raise, wait for ack, drop the cycle after, one low cycle.
    task automatic vid_read(input logic [7:0] page, input logic [12:0] ofs,
                            output logic [7:0] data, output int lat, output int ack_cyc);
        bus.vid_addr_page = page;
        bus.vid_addr      = ofs;
        bus.vid_rd_req    = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.vid_rd_ack !== 1'b1 && lat < 16);
        ack_cyc = cyc;
        tick();
        data           = bus.vid_data;
        bus.vid_rd_req = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " vid_rd_ack"}, 32'(bus.vid_rd_ack), 32'h0);
        check({tag, " cpu_ack"},    32'(bus.cpu_ack),    32'h0);
        check({tag, " mem_we"},     32'(bus.mem_we),     32'h0);
        check({tag, " vid_data"},   32'(bus.vid_data),   32'h0);
        check({tag, " cpu_rdata"},  32'(bus.cpu_rdata),  32'h0);
        check({tag, " mem_addr"},   32'(bus.mem_addr),   32'h0);
        check({tag, " mem_wdata"},  32'(bus.mem_wdata),  32'h0);
    endtask

    initial begin
        logic [7:0]  data;
        logic [20:0] a;
        int          lat;
        int          ack_cyc;
        int          prev_ack;
        int          base;
        int          cbase;
        int          v_at_cpu;
        bit          cpu_seen;
        logic [7:0]  cpu_data;

        reset_n           = 1'b0;
        bus.vid_addr      = '0;
        bus.vid_addr_page = '0;
        bus.vid_rd_req    = 1'b0;
        bus.cpu_addr      = '0;
        bus.cpu_wdata     = '0;
        bus.cpu_we        = 1'b0;
        bus.cpu_re        = 1'b0;

        // Reset values
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) tick();
        check_all_zero("post_reset");

        // Video read with the request held high
        bus.vid_addr_page = 8'h00;
        bus.vid_addr      = 13'h0401;
        bus.vid_rd_req    = 1'b1;
        tick();
        check("vrd c1 ack", 32'(bus.vid_rd_ack), 32'h0);
        check("vrd c1 mem_addr", 32'(bus.mem_addr), 32'h0401);
        tick();
        check("vrd c2 ack", 32'(bus.vid_rd_ack), 32'h1);
        check("vrd c2 data", 32'(bus.vid_data), 32'h41);
        base = vid_acks;
        repeat (8) tick();
        check("vrd held no 2nd ack", 32'(vid_acks - base), 32'h0);
        check("vrd data held", 32'(bus.vid_data), 32'h41);
        bus.vid_rd_req = 1'b0;
        tick();

        // Chroni-style stream 1025..1092
        base     = vid_acks;
        prev_ack = 0;
        for (int i = 0; i < 68; i++) begin
            a = 21'(1025 + i);
            vid_read(8'h00, a[12:0], data, lat, ack_cyc);
            check($sformatf("stream[%0d] data", i), 32'(data), 32'(8'(a[7:0] + 8'h40)));
            check($sformatf("stream[%0d] latency", i), 32'(lat), 32'd2);
            if (i > 0) check($sformatf("stream[%0d] period", i), 32'(ack_cyc - prev_ack), 32'd4);
            prev_ack = ack_cyc;
        end
        check("stream ack count", 32'(vid_acks - base), 32'd68);

        // CPU write then video read of the same byte via page/offset
        bus.cpu_addr  = 21'h1F_2001;
        bus.cpu_wdata = 8'hA5;
        bus.cpu_we    = 1'b1;
        tick();
        check("wr c1 mem_we", 32'(bus.mem_we), 32'h1);
        check("wr c1 mem_addr", 32'(bus.mem_addr), 32'h1F2001);
        check("wr c1 mem_wdata", 32'(bus.mem_wdata), 32'hA5);
        check("wr c1 cpu_ack", 32'(bus.cpu_ack), 32'h0);
        tick();
        check("wr c2 mem_we", 32'(bus.mem_we), 32'h0);
        check("wr c2 cpu_ack", 32'(bus.cpu_ack), 32'h1);
        bus.cpu_we = 1'b0;
        tick();
        check("wr c3 cpu_ack pulse", 32'(bus.cpu_ack), 32'h0);
        vid_read(8'hF9, 13'h0001, data, lat, ack_cyc);
        check("wr readback data", 32'(data), 32'hA5);
        check("wr readback latency", 32'(lat), 32'd2);

        // Starvation guard: video re-requests every IDLE, CPU read held
        bus.cpu_addr      = 21'h00_0402;
        bus.cpu_re        = 1'b1;
        bus.vid_addr_page = 8'h00;
        bus.vid_addr      = 13'h0401;
        bus.vid_rd_req    = 1'b1;
        base     = vid_acks;
        cbase    = cpu_acks;
        cpu_seen = 1'b0;
        v_at_cpu = -1;
        cpu_data = '0;
        for (int i = 0; i < 60; i++) begin
            tick();
            bus.vid_rd_req = (bus.vid_rd_ack === 1'b1) ? 1'b0 : 1'b1;
            if (bus.cpu_ack === 1'b1 && !cpu_seen) begin
                cpu_seen   = 1'b1;
                v_at_cpu   = vid_acks - base;
                cpu_data   = bus.cpu_rdata;
                bus.cpu_re = 1'b0;
            end
        end
        bus.vid_rd_req = 1'b0;
        check("starve vid acks before cpu", 32'(v_at_cpu), 32'd8);
        check("starve cpu ack count", 32'(cpu_acks - cbase), 32'd1);
        check("starve cpu_rdata", 32'(cpu_data), 32'h42);
        check("starve video resumed", 32'((vid_acks - base) > 8), 32'h1);
        repeat (4) tick();

        // Reset in cycle 1 of a video read
        bus.vid_addr_page = 8'h00;
        bus.vid_addr      = 13'h0403;
        bus.vid_rd_req    = 1'b1;
        tick();
        check("rst c1 mem_addr", 32'(bus.mem_addr), 32'h0403);
        base = vid_acks;
        reset_n        = 1'b0;
        bus.vid_rd_req = 1'b0;
        #1;
        check_all_zero("rst mid-read");
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        check("rst no ack", 32'(vid_acks - base), 32'h0);
        vid_read(8'h00, 13'h0403, data, lat, ack_cyc);
        check("rst reread data", 32'(data), 32'h43);
        check("rst reread latency", 32'(lat), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
